// File: rtl/ntru_pkg.sv
// Shared NTRU/HRSS encoding constants and the trit type.
package ntru_pkg;

  localparam int unsigned N_COEF = 701;
  localparam int unsigned TRITS_PER_BYTE = 5;
  localparam int unsigned SLOT_W = 3;
  localparam int unsigned ACC_W = 8;

  typedef logic [1:0] trit_t;

  localparam trit_t TRIT_ILLEGAL = 2'b11;

  // Base-3 digit weights, index = slot within the byte.
  localparam logic [4:0][7:0] POW3 = {8'd81, 8'd27, 8'd9, 8'd3, 8'd1};

  // Weight for a slot; slots beyond 4 never occur and weigh nothing.
  function automatic logic [ACC_W-1:0] pow3_weight(input logic [SLOT_W-1:0] slot);
    logic [ACC_W-1:0] w;
    case (slot)
      3'd0:    w = POW3[0];
      3'd1:    w = POW3[1];
      3'd2:    w = POW3[2];
      3'd3:    w = POW3[3];
      3'd4:    w = POW3[4];
      default: w = 8'd0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/s3_pack_step.sv
// One base-3 packing step: acc + trit * 3^slot, with illegal trits contributing zero.
module s3_pack_step
  import ntru_pkg::*;
(
  input  logic [ACC_W-1:0]  acc,
  input  trit_t             trit,
  input  logic [SLOT_W-1:0] slot,
  output logic [ACC_W-1:0]  acc_next,
  output logic              illegal
);

  logic [ACC_W-1:0] weight;

  // Add 0, 1x or 2x the slot weight; 2'b11 is flagged and treated as zero.
  always_comb begin
    weight   = pow3_weight(slot);
    illegal  = (trit == TRIT_ILLEGAL);
    acc_next = acc;
    case (trit)
      2'd1:    acc_next = acc + weight;
      2'd2:    acc_next = acc + ACC_W'(weight << 1);
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/s3_trit_packer.sv
// Packs a stream of mod-3 coefficients five per byte (base 3), flagging the final byte.
module s3_trit_packer
  import ntru_pkg::*;
#(
  parameter int unsigned N_COEF = ntru_pkg::N_COEF,
  parameter int unsigned CNT_W  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trit_valid,
  output logic       trit_ready,
  input  logic [1:0] trit_in,
  input  logic       trit_last,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic [7:0] byte_out,
  output logic       byte_last,
  output logic       err
);

  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_next;
  logic [SLOT_W-1:0] slot;
  logic [CNT_W-1:0]  cnt;
  logic              illegal;
  logic              accept;
  logic              is_final;
  logic              group_close;

  s3_pack_step u_step (
    .acc      (acc),
    .trit     (trit_in),
    .slot     (slot),
    .acc_next (acc_next),
    .illegal  (illegal)
  );

  // Handshake and group-close decode.
  always_comb begin
    trit_ready  = ~byte_valid | byte_ready;
    accept      = trit_valid & trit_ready;
    is_final    = (cnt == CNT_W'(N_COEF - 1));
    group_close = (slot == SLOT_W'(TRITS_PER_BYTE - 1)) | is_final;
  end

  // Accumulator, slot/coefficient counters, output byte register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      slot       <= '0;
      cnt        <= '0;
      byte_valid <= 1'b0;
      byte_out   <= 8'd0;
      byte_last  <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (byte_valid && byte_ready) begin
        byte_valid <= 1'b0;
      end
      if (accept) begin
        if (group_close) begin
          byte_out   <= acc_next;
          byte_last  <= is_final;
          byte_valid <= 1'b1;
          acc        <= '0;
          slot       <= '0;
        end else begin
          acc  <= acc_next;
          slot <= slot + SLOT_W'(1);
        end
        cnt <= is_final ? '0 : cnt + CNT_W'(1);
        if (illegal || (trit_last != is_final)) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule
